// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: pipelined carry-lookahead adder/subtractor resolving one GROUP-bit lookahead group per stage
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / GROUP;

    logic adv;
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic [WIDTH-1:0] in_a [STAGES];
    logic [WIDTH-1:0] in_b [STAGES];
    logic [WIDTH-1:0] in_s [STAGES];
    logic [WIDTH-1:0] nx_s [STAGES];
    logic [STAGES-1:0] st_c, st_v, in_c, in_v, nx_c;
    logic [GROUP-1:0] p, g;
    logic [GROUP:0] c;
    logic nx_o, ovf_r;

    // every carry is a flat sum of products of g, p and the group carry-in
    function automatic logic [GROUP:0] cla(input logic [GROUP-1:0] pp, input logic [GROUP-1:0] gg, input logic c0);
        logic [GROUP:0] cc;
        logic t;
        cc = '0;
        cc[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            cc[i+1] = gg[i];
            t = pp[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc[i+1] = cc[i+1] | (t & gg[j]);
                t = t & pp[j];
            end
            cc[i+1] = cc[i+1] | (t & c0);
        end
        return cc;
    endfunction

    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign out_valid = st_v[STAGES-1];
    assign sum       = st_s[STAGES-1];
    assign cout      = st_c[STAGES-1];
    assign ovf       = ovf_r;

    always_comb begin
        in_a[0] = a;
        in_b[0] = sub ? ~b : b;
        in_c[0] = sub | cin;
        in_v[0] = in_valid;
        in_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            in_a[k] = st_a[k-1];
            in_b[k] = st_b[k-1];
            in_c[k] = st_c[k-1];
            in_v[k] = st_v[k-1];
            in_s[k] = st_s[k-1];
        end
        p = '0;
        g = '0;
        c = '0;
        nx_c = '0;
        nx_o = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            p = in_a[k][k*GROUP +: GROUP] ^ in_b[k][k*GROUP +: GROUP];
            g = in_a[k][k*GROUP +: GROUP] & in_b[k][k*GROUP +: GROUP];
            c = cla(p, g, in_c[k]);
            nx_s[k] = in_s[k];
            nx_s[k][k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
            nx_c[k] = c[GROUP];
            nx_o = c[GROUP] ^ c[GROUP-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_s[k] <= '0;
            end
            st_c  <= '0;
            st_v  <= '0;
            ovf_r <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                st_a[k] <= in_a[k];
                st_b[k] <= in_b[k];
                st_s[k] <= nx_s[k];
            end
            st_c  <= nx_c;
            st_v  <= in_v;
            ovf_r <= nx_o;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for the 16/4 adder plus random streams on 8/2 and 4/4 builds
module tb_pipelined_cla_adder;
    typedef struct {
        int exp;
        int acc;
        int st;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    int errors = 0, checks = 0, cyc = 0, stalls = 0;
    ent_t q[$];
    ent_t me;
    bit held = 0;
    logic [31:0] held_val;
    bit done [2];
    logic [15:0] x, y;
    bit ci, sb;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // packed as {ovf, cout, sum[w-1:0]}
    function automatic int model(input int w, input int xa, input int yb, input bit c_in, input bit s_ub);
        int mask, yy, s, full;
        bit sa, sy, ov, co;
        mask = (1 << w) - 1;
        yy = s_ub ? (~yb & mask) : yb;
        full = xa + yy + (s_ub ? 1 : int'(c_in));
        s = full & mask;
        co = full[w];
        sa = xa[w-1];
        sy = yb[w-1];
        ov = s_ub ? (sa != sy && s[w-1] != sa) : (sa == sy && s[w-1] != sa);
        return (int'(ov) << (w + 1)) | (int'(co) << w) | s;
    endfunction

    task automatic send(input logic [15:0] xa, input logic [15:0] yb, input logic c_in, input logic s_ub, input int exp);
        bit ok;
        ent_t e;
        in_valid = 1'b1;
        a = xa;
        b = yb;
        cin = c_in;
        sub = s_ub;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) begin
                e.exp = exp;
                e.acc = cyc + 1;
                e.st = stalls;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("rdy", in_ready, !(out_valid && !out_ready));
            if (held) begin
                check("hold", {ovf, cout, sum}, held_val);
                check("hold_v", out_valid, 1);
            end
            held = out_valid && !out_ready;
            held_val = {ovf, cout, sum};
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("stale", out_valid, 0);
                else begin
                    me = q.pop_front();
                    check("res", {ovf, cout, sum}, me.exp);
                    check("lat", cyc, me.acc + 3 + stalls - me.st);
                end
            end
            if (out_valid && !out_ready) stalls++;
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_v", out_valid, 0);
        check("rst_s", sum, 0);
        check("rst_rdy", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 'h05555);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 'h10000);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 'h28000);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 'h0FFFE);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 'h37FFF);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 'h10000);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 'h30000);
        drain();
        fork
            for (int i = 0; i < 8; i++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                ci = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                send(x, y, ci, sb, model(16, int'(x), int'(y), ci, sb));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 'h03333);
        send(16'hF000, 16'h1000, 1'b0, 1'b0, 'h10000);
        send(16'h0001, 16'h0002, 1'b0, 1'b1, 'h0FFFF);
        repeat (2) @(posedge clk);
        #1 check("pre_rst_v", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst2_v", out_valid, 0);
        check("rst2_s", sum, 0);
        check("rst2_rdy", in_ready, 1);
        q.delete();
        held = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(16'h00FF, 16'h0F01, 1'b1, 1'b0, 'h01001);
        drain();
        for (int t = 0; t < 60000 && !(done[0] && done[1]); t++) @(posedge clk);
        check("rnd_done", done[0] && done[1], 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    for (genvar i = 0; i < 2; i++) begin : g_rnd
        localparam int W = i == 0 ? 8 : 4;
        localparam int G = i == 0 ? 2 : 4;
        localparam int S = W / G;
        logic r_rst, iv, ir, rc, rs, ov, orr, co, ovf_o;
        logic [W-1:0] ra, rb, s;
        int sent = 0, n_st = 0;
        ent_t rq[$];
        ent_t e;

        pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
            .clk(clk), .rst(r_rst), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(rc), .sub(rs),
            .out_valid(ov), .out_ready(orr),
            .sum(s), .cout(co), .ovf(ovf_o)
        );

        initial begin
            r_rst = 1'b1;
            iv = 1'b0;
            ra = '0;
            rb = '0;
            rc = 1'b0;
            rs = 1'b0;
            orr = 1'b0;
            done[i] = 1'b0;
            repeat (2) @(posedge clk);
            #1 r_rst = 1'b0;
            while (sent < 10000) begin
                iv = $urandom_range(0, 3) != 0;
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                orr = $urandom_range(0, 3) != 0;
                @(posedge clk);
                #1;
            end
            iv = 1'b0;
            orr = 1'b1;
            for (int t = 0; t < 100 && rq.size() != 0; t++) @(posedge clk);
            #1;
            check("r_drain", rq.size(), 0);
            done[i] = 1'b1;
        end

        always @(negedge clk) begin
            if (!r_rst) begin
                if (iv && ir) begin
                    e.exp = model(W, int'(ra), int'(rb), rc, rs);
                    e.acc = cyc + 1;
                    e.st = n_st;
                    rq.push_back(e);
                    sent++;
                end
                if (ov && orr) begin
                    if (rq.size() == 0) check("r_stale", ov, 0);
                    else begin
                        e = rq.pop_front();
                        check("r_res", {ovf_o, co, s}, e.exp);
                        check("r_lat", cyc, e.acc + S - 1 + n_st - e.st);
                    end
                end
                if (ov && !orr) n_st++;
            end
        end
    end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. It splits a WIDTH-bit add into WIDTH/GROUP lookahead groups and resolves one group per pipeline stage. It accepts one operation per clock under a valid/ready handshake and returns sum, carry-out and signed overflow. It generalises the 4-bit lookahead adder into the wide, throughput-oriented arithmetic unit used by the datapath labs.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group; one group is resolved per stage.
- STAGES (derived, localparam), WIDTH/GROUP, pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow (A >= B unsigned).
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- Accept a beat when in_valid && in_ready.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1) takes bits [k*GROUP +: GROUP] and the registered group carry from stage k-1 (c0 for k=0).
- Within a stage:
  - per-bit P = a^b_eff, G = a&b_eff.
  - lookahead carries c[i+1] = G[i] | P[i]&c[i], fully expanded; no ripple inside a group.
  - sum bits = P ^ c.
- Each stage registers:
  - its sum slice and all completed lower slices;
  - its group carry-out;
  - the still-unprocessed upper bits of a and b_eff (operand skew);
  - a valid bit.
- Last stage additionally registers ovf from the MSB carry-in and carry-out.
- Pipeline advance: adv = !(out_valid && !out_ready).
  - When adv=1, all stages shift one step; an empty input slot inserts a bubble (valid=0).
  - When adv=0, every stage register holds.
- in_ready = adv (combinational from out_valid and out_ready only; no dependence on in_valid).
- Results leave in acceptance order; none are lost, duplicated or reordered.
- sum, cout and ovf hold stable while out_valid=1 and out_ready=0.

## Timing
- Latency: a beat accepted at edge n presents out_valid=1 with its result after edge n+STAGES-1, i.e. STAGES register stages.
- Throughput: one beat per clock while out_ready=1.
- Reset (asynchronous, immediate):
  - all stage valid bits, out_valid, sum, cout and ovf are 0;
  - in_ready follows combinationally as 1.
- Reset mid-operation discards all in-flight beats; none appear after release.
- First accept is possible on the first rising edge after rst deasserts.
- Simultaneous output pop and input push in a full pipeline: both occur, occupancy is unchanged.
- Carry wrap: the carry out of bit WIDTH-1 goes only to cout; sum wraps modulo 2^WIDTH.
- WIDTH == GROUP (STAGES=1) degenerates to a single registered CLA with latency 1.

## Test plan
- WIDTH=16, GROUP=4: a=0x1234, b=0x4321, cin=0, sub=0 -> 4 cycles later sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; carry propagates through all 4 stages. Repeat with a=0x7FFF -> sum=0x8000, cout=0, ovf=1.
- sub=1:
  - a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Stall: 8 back-to-back beats with random operands, out_ready held low 3 cycles mid-stream -> in_ready=0 exactly while stalled, outputs hold stable, all 8 results match the golden model in order.
- Reset: assert rst with 3 beats in flight -> out_valid=0, sum=0 at once; after release no stale result appears; the next beat completes with latency 4.
- WIDTH=8, GROUP=2 and WIDTH=4, GROUP=4: 10k random add/sub beats with random in_valid and out_ready -> bit-exact vs behavioural A±B; latency 4 and 1 respectively.
